// File: rtl/nexys2_input_port_if.sv
// Board-side bundle for the Nexys2 input port: raw switch/button pins, the
// event clear mask from the CPU, and the conditioned levels and press events.
interface nexys2_input_port_if #(
  parameter int NSW  = 8,
  parameter int NBTN = 4
);
  logic [NSW-1:0]  sw_raw;
  logic [NBTN-1:0] btn_raw;
  logic [NBTN-1:0] evt_clr;
  logic [NSW-1:0]  sw_level;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_event;
  logic            evt_any;

  modport master (
    output sw_raw,
    output btn_raw,
    output evt_clr,
    input  sw_level,
    input  btn_level,
    input  btn_event,
    input  evt_any
  );

  modport slave (
    input  sw_raw,
    input  btn_raw,
    input  evt_clr,
    output sw_level,
    output btn_level,
    output btn_event,
    output evt_any
  );
endinterface

// File: rtl/nexys2_input_port.sv
// Nexys2 switch/button conditioner: per-input 2-flop synchronizer and
// counter debouncer, plus sticky button press latches with a clear mask.
module nexys2_input_port #(
  parameter int NSW             = 8,
  parameter int NBTN            = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  nexys2_input_port_if.slave  bus
);

  localparam int NIN = NSW + NBTN;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NIN-1:0]  raw_in;
  logic [NIN-1:0]  sync1_q;
  logic [NIN-1:0]  sync2_q;
  logic [NIN-1:0]  stable_q;
  logic [NIN-1:0]  stable_d;
  logic [CW-1:0]   cnt_q [NIN];
  logic [CW-1:0]   cnt_d [NIN];
  logic [NBTN-1:0] btn_rise;
  logic [NBTN-1:0] btn_event_q;
  logic [NBTN-1:0] btn_event_d;
  logic            evt_any_q;
  logic            evt_any_d;

  // Buttons sit above switches so one loop handles every input alike.
  assign raw_in = {bus.btn_raw, bus.sw_raw};

  // Synchronizer, debounce state and event latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      btn_event_q <= '0;
      evt_any_q   <= 1'b0;
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= raw_in;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      btn_event_q <= btn_event_d;
      evt_any_q   <= evt_any_d;
      for (int i = 0; i < NIN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Per-input debounce: any agreeing sample restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Press events: a new debounced press beats a same-cycle clear.
  always_comb begin
    btn_rise    = stable_d[NIN-1:NSW] & ~stable_q[NIN-1:NSW];
    btn_event_d = (btn_event_q & ~bus.evt_clr) | btn_rise;
    evt_any_d   = |btn_event_d;
  end

  assign bus.sw_level  = stable_q[NSW-1:0];
  assign bus.btn_level = stable_q[NIN-1:NSW];
  assign bus.btn_event = btn_event_q;
  assign bus.evt_any   = evt_any_q;

endmodule

// File: tb/tb_nexys2_input_port.sv
// Directed bench for nexys2_input_port with DEBOUNCE_CYCLES=4 (6-edge latency).
module tb_nexys2_input_port;

  logic clk;
  logic clk_en;
  logic reset;
  int   n_checks;
  int   n_fails;

  nexys2_input_port_if #(.NSW(8), .NBTN(4)) bus ();

  nexys2_input_port #(
    .NSW(8),
    .NBTN(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] sw, input logic [3:0] lvl,
                           input logic [3:0] evt, input logic any);
    check({tag, ".sw_level"},  bus.sw_level, sw);
    check({tag, ".btn_level"}, {4'h0, bus.btn_level}, {4'h0, lvl});
    check({tag, ".btn_event"}, {4'h0, bus.btn_event}, {4'h0, evt});
    check({tag, ".evt_any"},   {7'h00, bus.evt_any}, {7'h00, any});
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    clk_en      = 1'b0;
    reset       = 1'b0;
    bus.sw_raw  = 8'hFF;
    bus.btn_raw = 4'hF;
    bus.evt_clr = 4'h0;

    // Reset with no clock running, raw inputs all ones.
    #1 reset = 1'b1;
    #1 check_all("reset_async", 8'h00, 4'h0, 4'h0, 1'b0);
    #3 reset = 1'b0;
    clk_en = 1'b1;
    tick(5);
    check_all("powerup_e5", 8'h00, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_all("powerup_e6", 8'hFF, 4'hF, 4'hF, 1'b1);

    // Settle everything low and clear the power-up events.
    bus.sw_raw  = 8'h00;
    bus.btn_raw = 4'h0;
    bus.evt_clr = 4'hF;
    tick(1);
    bus.evt_clr = 4'h0;
    check("clear_all.btn_event", {4'h0, bus.btn_event}, 8'h00);
    tick(7);
    check_all("settled_low", 8'h00, 4'h0, 4'h0, 1'b0);

    // Switch latency.
    bus.sw_raw = 8'h5A;
    tick(5);
    check("sw_lat_e5", bus.sw_level, 8'h00);
    tick(1);
    check_all("sw_lat_e6", 8'h5A, 4'h0, 4'h0, 1'b0);

    // Bounce on button 0: 1,0,1,0 then steady 1.
    bus.btn_raw = 4'h1; tick(1);
    bus.btn_raw = 4'h0; tick(1);
    bus.btn_raw = 4'h1; tick(1);
    bus.btn_raw = 4'h0; tick(1);
    bus.btn_raw = 4'h1;
    tick(5);
    check_all("bounce_e5", 8'h5A, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_all("bounce_e6", 8'h5A, 4'h1, 4'h1, 1'b1);

    // Press button 1 to get events 0b0011.
    bus.btn_raw = 4'h3;
    tick(6);
    check_all("press1", 8'h5A, 4'h3, 4'h3, 1'b1);

    // Clear on an already-zero bit is a no-op.
    bus.evt_clr = 4'h8; tick(1); bus.evt_clr = 4'h0;
    check_all("clr_zero_bit", 8'h5A, 4'h3, 4'h3, 1'b1);
    bus.evt_clr = 4'h1; tick(1); bus.evt_clr = 4'h0;
    check_all("clr_bit0", 8'h5A, 4'h3, 4'h2, 1'b1);
    bus.evt_clr = 4'h2; tick(1); bus.evt_clr = 4'h0;
    check_all("clr_bit1", 8'h5A, 4'h3, 4'h0, 1'b0);

    // Set-wins: clear bit 2 on the edge its level rises.
    bus.btn_raw = 4'h7;
    tick(5);
    check_all("setwins_e5", 8'h5A, 4'h3, 4'h0, 1'b0);
    bus.evt_clr = 4'h4; tick(1); bus.evt_clr = 4'h0;
    check_all("setwins_e6", 8'h5A, 4'h7, 4'h4, 1'b1);
    bus.btn_raw = 4'h3;
    tick(6);
    check_all("release2", 8'h5A, 4'h3, 4'h4, 1'b1);

    // Return buttons low and clear events before the mid-debounce reset.
    bus.btn_raw = 4'h0;
    bus.evt_clr = 4'hF; tick(1); bus.evt_clr = 4'h0;
    tick(6);
    check_all("pre_midreset", 8'h5A, 4'h0, 4'h0, 1'b0);

    // Reset between edges 3 and 4 of a button 1 press.
    bus.btn_raw = 4'h2;
    tick(3);
    #2 reset = 1'b1;
    #1 check_all("midreset", 8'h00, 4'h0, 4'h0, 1'b0);
    #1 reset = 1'b0;
    tick(5);
    check_all("post_reset_e5", 8'h00, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_all("post_reset_e6", 8'h5A, 4'h2, 4'h2, 1'b1);
    tick(3);
    check_all("post_reset_hold", 8'h5A, 4'h2, 4'h2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
